// File: rtl/tlb_op_sequencer.sv
// TLB maintenance sequencer. It takes one LoongArch TLB instruction at a time from MEM,
// blocks and drains data-side translation, then issues a single operation on the shared
// TLB ports. Search results go back to the CSR file, and a refetch is requested after any
// operation that modifies the TLB.
module tlb_op_sequencer #(
  parameter int unsigned TLBNUM = 32,
  parameter int unsigned IDX_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [2:0]       op_type_i,
  input  logic [4:0]       inv_op_i,
  input  logic [9:0]       inv_asid_i,
  input  logic [18:0]      inv_vpn_i,
  input  logic             data_busy_i,
  output logic             trans_block_o,
  output logic             tlbserch_en_o,
  input  logic             serch_tlb_finish_i,
  input  logic             srch_found_i,
  input  logic [IDX_W-1:0] srch_index_i,
  output logic             tlb_wen_o,
  output logic             tlb_fill_en_o,
  output logic [IDX_W-1:0] rand_index_o,
  output logic             tlbinv_en_o,
  output logic [4:0]       tlbinv_op_o,
  output logic [9:0]       tlbinv_asid_o,
  output logic [18:0]      tlbinv_vpn_o,
  output logic             tlbrd_en_o,
  output logic             srch_wr_o,
  output logic [IDX_W-1:0] srch_idx_o,
  output logic             srch_ne_o,
  output logic             op_done_o,
  output logic             op_excp_o,
  output logic             refetch_req_o
);

  localparam logic [2:0] OpSrch = 3'd0;
  localparam logic [2:0] OpRd   = 3'd1;
  localparam logic [2:0] OpWr   = 3'd2;
  localparam logic [2:0] OpFill = 3'd3;
  localparam logic [2:0] OpInv  = 3'd4;

  // INVTLB op codes 0..6 are defined; anything above raises INE.
  localparam logic [4:0] InvOpMax = 5'd6;

  typedef enum logic [3:0] {
    StIdle,
    StDrain,
    StSrch,
    StSrchWait,
    StRd,
    StWr,
    StFill,
    StInv,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic             excp_q, excp_d;
  logic [4:0]       inv_op_q, inv_op_d;
  logic [9:0]       inv_asid_q, inv_asid_d;
  logic [18:0]      inv_vpn_q, inv_vpn_d;
  logic             found_q, found_d;
  logic [IDX_W-1:0] sidx_q, sidx_d;
  logic [IDX_W-1:0] rand_q, rand_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic op_illegal;
  logic srch_done;

  assign accept = op_valid_i && (state_q == StIdle);

  // Reserved op_type values and undefined INVTLB op codes both end as INE.
  assign op_illegal = (op_type_i > OpInv) || ((op_type_i == OpInv) && (inv_op_i > InvOpMax));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: drain the data-side request, then perform exactly one port action.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (op_valid_i) begin
          state_d = op_illegal ? StDone : StDrain;
        end
      end
      StDrain: begin
        // A flush can only cancel the op before it has touched the TLB.
        if (flush_i) begin
          state_d = StIdle;
        end else if (!data_busy_i) begin
          case (op_q)
            OpSrch:  state_d = StSrch;
            OpRd:    state_d = StRd;
            OpWr:    state_d = StWr;
            OpFill:  state_d = StFill;
            OpInv:   state_d = StInv;
            default: state_d = StDone;
          endcase
        end
      end
      StSrch:     state_d = StSrchWait;
      StSrchWait: begin
        if (serch_tlb_finish_i) begin
          state_d = StDone;
        end
      end
      StRd:       state_d = StDone;
      StWr:       state_d = StDone;
      StFill:     state_d = StDone;
      StInv:      state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Next-state logic for the operation context, the search result and the fill index.
  always_comb begin
    op_d       = op_q;
    excp_d     = excp_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vpn_d  = inv_vpn_q;
    found_d    = found_q;
    sidx_d     = sidx_q;
    rand_d     = rand_q;
    cnt_d      = (cnt_q == IDX_W'(TLBNUM - 1)) ? '0 : cnt_q + 1'b1;

    if (accept) begin
      op_d   = op_type_i;
      excp_d = op_illegal;
      // Invalidate operands change only for a legal INVTLB, so they stay stable otherwise.
      if ((op_type_i == OpInv) && !op_illegal) begin
        inv_op_d   = inv_op_i;
        inv_asid_d = inv_asid_i;
        inv_vpn_d  = inv_vpn_i;
      end
    end

    if ((state_q == StSrchWait) && serch_tlb_finish_i) begin
      found_d = srch_found_i;
      sidx_d  = srch_index_i;
    end

    // Snapshot the free-running counter on the way into FILL so the index cannot move
    // while the write pulse is on the port.
    if ((state_q == StDrain) && (state_d == StFill)) begin
      rand_d = cnt_q;
    end
  end

  // Operation context, search result, fill index and free-running counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OpSrch;
      excp_q     <= 1'b0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vpn_q  <= '0;
      found_q    <= 1'b0;
      sidx_q     <= '0;
      rand_q     <= '0;
      cnt_q      <= '0;
    end else begin
      op_q       <= op_d;
      excp_q     <= excp_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_vpn_q  <= inv_vpn_d;
      found_q    <= found_d;
      sidx_q     <= sidx_d;
      rand_q     <= rand_d;
      cnt_q      <= cnt_d;
    end
  end

  assign srch_done = (state_q == StDone) && !excp_q && (op_q == OpSrch);

  // Moore outputs: every pulse is decoded from the registered state, so it drops with reset.
  always_comb begin
    op_ready_o    = 1'b0;
    trans_block_o = 1'b1;
    tlbserch_en_o = 1'b0;
    tlbrd_en_o    = 1'b0;
    tlb_wen_o     = 1'b0;
    tlb_fill_en_o = 1'b0;
    tlbinv_en_o   = 1'b0;
    srch_wr_o     = 1'b0;
    srch_ne_o     = 1'b0;
    srch_idx_o    = '0;
    op_done_o     = 1'b0;
    op_excp_o     = 1'b0;
    refetch_req_o = 1'b0;
    case (state_q)
      StIdle: begin
        op_ready_o    = 1'b1;
        trans_block_o = 1'b0;
      end
      StSrch: tlbserch_en_o = 1'b1;
      StRd:   tlbrd_en_o    = 1'b1;
      StWr:   tlb_wen_o     = 1'b1;
      StFill: tlb_fill_en_o = 1'b1;
      StInv:  tlbinv_en_o   = 1'b1;
      StDone: begin
        op_done_o     = 1'b1;
        op_excp_o     = excp_q;
        refetch_req_o = !excp_q && ((op_q == OpWr) || (op_q == OpFill) || (op_q == OpInv));
        srch_wr_o     = srch_done;
        srch_ne_o     = srch_done && !found_q;
        srch_idx_o    = (srch_done && found_q) ? sidx_q : '0;
      end
      default: ;
    endcase
  end

  assign rand_index_o  = rand_q;
  assign tlbinv_op_o   = inv_op_q;
  assign tlbinv_asid_o = inv_asid_q;
  assign tlbinv_vpn_o  = inv_vpn_q;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer. A transaction-level model turns each issued op into
// a per-cycle expected output timeline, and a negedge process compares the DUT against it.
module tb_tlb_op_sequencer;

  localparam int unsigned TLBNUM = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic op_valid = 1'b0;
  logic op_ready;
  logic [2:0] op_type = '0;
  logic [4:0] inv_op = '0;
  logic [9:0] inv_asid = '0;
  logic [18:0] inv_vpn = '0;
  logic data_busy = 1'b0;
  logic trans_block, tlbserch_en;
  logic serch_tlb_finish = 1'b0;
  logic srch_found = 1'b0;
  logic [IDX_W-1:0] srch_index = '0;
  logic tlb_wen, tlb_fill_en, tlbinv_en, tlbrd_en;
  logic [IDX_W-1:0] rand_index;
  logic [4:0] tlbinv_op;
  logic [9:0] tlbinv_asid;
  logic [18:0] tlbinv_vpn;
  logic srch_wr, srch_ne, op_done, op_excp, refetch_req;
  logic [IDX_W-1:0] srch_idx;

  always #5 clk = ~clk;

  tlb_op_sequencer #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_type_i(op_type),
    .inv_op_i(inv_op), .inv_asid_i(inv_asid), .inv_vpn_i(inv_vpn),
    .data_busy_i(data_busy), .trans_block_o(trans_block), .tlbserch_en_o(tlbserch_en),
    .serch_tlb_finish_i(serch_tlb_finish), .srch_found_i(srch_found),
    .srch_index_i(srch_index), .tlb_wen_o(tlb_wen), .tlb_fill_en_o(tlb_fill_en),
    .rand_index_o(rand_index), .tlbinv_en_o(tlbinv_en), .tlbinv_op_o(tlbinv_op),
    .tlbinv_asid_o(tlbinv_asid), .tlbinv_vpn_o(tlbinv_vpn), .tlbrd_en_o(tlbrd_en),
    .srch_wr_o(srch_wr), .srch_idx_o(srch_idx), .srch_ne_o(srch_ne),
    .op_done_o(op_done), .op_excp_o(op_excp), .refetch_req_o(refetch_req)
  );

  typedef struct packed {
    logic ready, block, srch, wen, fill, inv, rd, swr, done, excp, refetch;
    logic [4:0] sidx;
    logic sne;
    logic [4:0] rnd;
    logic [4:0] iop;
    logic [9:0] iasid;
    logic [18:0] ivpn;
  } obs_t;

  obs_t exp_q [MAXC];
  obs_t samp [MAXC];
  int gcyc = 0;   // posedges since time 0
  int srst = 0;   // posedges since the last reset release
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) gcyc <= gcyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) srst <= 0;
    else srst <= srst + 1;
  end

  function automatic obs_t idle_o();
    obs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t busy_o();
    obs_t o = '0;
    o.block = 1'b1;
    return o;
  endfunction

  function automatic logic [10:0] ctrl(obs_t o);
    return {o.ready, o.block, o.srch, o.wen, o.fill, o.inv, o.rd, o.swr, o.done, o.excp,
            o.refetch};
  endfunction

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, gcyc, got, want);
    end
  endfunction

  // Model: an op started in cycle a spends one IDLE cycle being accepted, drains while
  // data_busy is high, does one action cycle (plus the wait for a search result), then one
  // DONE cycle. Returns the last non-idle cycle.
  function automatic int predict(int a, int op, int iop, int asid, int vpn, int busy_n,
                                 int flush_off, int sdelay, bit found, int sidx, int cnt_now);
    obs_t o;
    int x;
    if (op > 4 || (op == 4 && iop > 6)) begin
      o = busy_o();
      o.done = 1'b1;
      o.excp = 1'b1;
      exp_q[a+1] = o;
      return a + 1;
    end
    if (flush_off >= 1 && flush_off <= busy_n + 1) begin
      for (int k = 1; k <= flush_off; k++) exp_q[a+k] = busy_o();
      return a + flush_off;
    end
    for (int k = 1; k <= busy_n + 1; k++) exp_q[a+k] = busy_o();
    x = a + busy_n + 2;
    o = busy_o();
    case (op)
      0: begin
        o.srch = 1'b1;
        exp_q[x] = o;
        for (int k = 1; k <= sdelay; k++) exp_q[x+k] = busy_o();
        x = x + sdelay;
      end
      1: begin o.rd = 1'b1; exp_q[x] = o; end
      2: begin o.wen = 1'b1; exp_q[x] = o; end
      3: begin
        o.fill = 1'b1;
        o.rnd = 5'((cnt_now + busy_n + 1) % TLBNUM);
        exp_q[x] = o;
      end
      default: begin
        o.inv = 1'b1;
        o.iop = 5'(iop);
        o.iasid = 10'(asid);
        o.ivpn = 19'(vpn);
        exp_q[x] = o;
      end
    endcase
    o = busy_o();
    o.done = 1'b1;
    o.refetch = (op >= 2);
    if (op == 0) begin
      o.swr = 1'b1;
      o.sne = !found;
      o.sidx = found ? 5'(sidx) : 5'd0;
    end
    exp_q[x+1] = o;
    return x + 1;
  endfunction

  task automatic sample_cmp();
    obs_t d, e;
    d = '0;
    d.ready = op_ready; d.block = trans_block; d.srch = tlbserch_en; d.wen = tlb_wen;
    d.fill = tlb_fill_en; d.inv = tlbinv_en; d.rd = tlbrd_en; d.swr = srch_wr;
    d.done = op_done; d.excp = op_excp; d.refetch = refetch_req; d.sidx = srch_idx;
    d.sne = srch_ne; d.rnd = rand_index; d.iop = tlbinv_op; d.iasid = tlbinv_asid;
    d.ivpn = tlbinv_vpn;
    if (gcyc >= MAXC) return;
    samp[gcyc] = d;
    e = exp_q[gcyc];
    chk("ctrl{rdy,blk,srch,wen,fill,inv,rd,swr,done,excp,refetch}", 32'(ctrl(d)),
        32'(ctrl(e)));
    if (e.swr) begin
      chk("srch_idx", 32'(d.sidx), 32'(e.sidx));
      chk("srch_ne", 32'(d.sne), 32'(e.sne));
    end
    if (e.fill) chk("rand_index", 32'(d.rnd), 32'(e.rnd));
    if (e.inv) begin
      chk("tlbinv_op", 32'(d.iop), 32'(e.iop));
      chk("tlbinv_asid", 32'(d.iasid), 32'(e.iasid));
      chk("tlbinv_vpn", 32'(d.ivpn), 32'(e.ivpn));
    end
  endtask

  always @(negedge clk) sample_cmp();

  // Called and returns just after a posedge; a is the cycle op_valid is presented.
  task automatic run_op(input int op, input int iop, input int asid, input int vpn,
                        input int busy_n, input int flush_off, input int sdelay,
                        input bit found, input int sidx, output int a);
    int e;
    a = gcyc;
    e = predict(a, op, iop, asid, vpn, busy_n, flush_off, sdelay, found, sidx, srst);
    for (int k = 0; k <= e - a + 1; k++) begin
      op_valid = (k == 0);
      op_type = 3'(op);
      inv_op = 5'(iop);
      inv_asid = 10'(asid);
      inv_vpn = 19'(vpn);
      data_busy = (k >= 1 && k <= busy_n);
      flush = (k == flush_off);
      serch_tlb_finish = (op == 0 && k == busy_n + 2 + sdelay);
      srch_found = found;
      srch_index = 5'(sidx);
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    data_busy = 1'b0;
    flush = 1'b0;
    serch_tlb_finish = 1'b0;
  endtask

  initial begin
    int a, r1, r2;
    logic any;
    for (int i = 0; i < MAXC; i++) exp_q[i] = idle_o();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({op_ready, trans_block, tlbserch_en, tlb_wen, tlb_fill_en, tlbinv_en,
        tlbrd_en, srch_wr, op_done, op_excp, refetch_req}), 32'h400);
    chk("reset_rand_index", 32'(rand_index), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // WR, no drain: wen in cycle 2, done+refetch in 3, ready in 4.
    run_op(2, 0, 0, 0, 0, -1, 1, 1'b0, 0, a);
    chk("wr_c1_no_wen", 32'(samp[a+1].wen), 32'd0);
    chk("wr_c2_wen", 32'(samp[a+2].wen), 32'd1);
    chk("wr_c3_wen_off", 32'(samp[a+3].wen), 32'd0);
    chk("wr_c3_done_refetch", 32'({samp[a+3].done, samp[a+3].refetch}), 32'd3);
    chk("wr_c4_ready", 32'(samp[a+4].ready), 32'd1);

    // SRCH hit at index 17, result one cycle after the search pulse.
    run_op(0, 0, 0, 0, 0, -1, 1, 1'b1, 17, a);
    chk("srch_hit_wr", 32'(samp[a+4].swr), 32'd1);
    chk("srch_hit_idx", 32'(samp[a+4].sidx), 32'd17);
    chk("srch_hit_ne", 32'(samp[a+4].sne), 32'd0);
    chk("srch_hit_no_refetch", 32'(samp[a+4].refetch), 32'd0);

    // SRCH miss: NE set, index forced to 0 even though the port shows 9.
    run_op(0, 0, 0, 0, 0, -1, 3, 1'b0, 9, a);
    chk("srch_miss_ne", 32'(samp[a+6].sne), 32'd1);
    chk("srch_miss_idx", 32'(samp[a+6].sidx), 32'd0);

    run_op(1, 0, 0, 0, 0, -1, 1, 1'b0, 0, a);
    chk("rd_pulse", 32'(samp[a+2].rd), 32'd1);

    // WR behind a 3-cycle busy data stage.
    run_op(2, 0, 0, 0, 3, -1, 1, 1'b0, 0, a);
    chk("drain_block_c1", 32'(samp[a+1].block), 32'd1);
    chk("drain_no_wen_c4", 32'(samp[a+4].wen), 32'd0);
    chk("drain_wen_c5", 32'(samp[a+5].wen), 32'd1);
    chk("drain_done_c6", 32'(samp[a+6].done), 32'd1);

    // Flush while draining cancels the op.
    run_op(2, 0, 0, 0, 3, 2, 1, 1'b0, 0, a);
    any = 1'b0;
    for (int k = a; k <= a + 3; k++) any = any | samp[k].done | samp[k].wen;
    chk("flush_drain_no_done_wen", 32'(any), 32'd0);
    chk("flush_drain_idle_c3", 32'(samp[a+3].ready), 32'd1);

    // Flush in the action cycle is ignored.
    run_op(2, 0, 0, 0, 0, 2, 1, 1'b0, 0, a);
    chk("flush_late_done", 32'(samp[a+3].done), 32'd1);

    run_op(6, 0, 0, 0, 0, -1, 1, 1'b0, 0, a);
    chk("rsvd_done_excp", 32'({samp[a+1].done, samp[a+1].excp, samp[a+1].refetch}), 32'd6);

    run_op(4, 7, 12, 5, 0, -1, 1, 1'b0, 0, a);
    chk("inv7_done_excp", 32'({samp[a+1].done, samp[a+1].excp, samp[a+1].refetch}), 32'd6);
    chk("inv7_no_inv", 32'(samp[a+1].inv | samp[a+2].inv), 32'd0);

    run_op(4, 5, 'h3A, 'h12345, 0, -1, 1, 1'b0, 0, a);
    chk("inv5_pulse", 32'(samp[a+2].inv), 32'd1);
    chk("inv5_op", 32'(samp[a+2].iop), 32'd5);
    chk("inv5_asid", 32'(samp[a+2].iasid), 32'h3A);
    chk("inv5_refetch", 32'(samp[a+3].refetch), 32'd1);

    run_op(4, 6, 'h3FF, 'h7FFFF, 1, -1, 1, 1'b0, 0, a);
    run_op(3, 0, 0, 0, 2, -1, 1, 1'b0, 0, a);

    // Reset asserted in SRCH_WAIT: every output drops at once.
    a = gcyc;
    void'(predict(a, 0, 0, 0, 0, 0, -1, 8, 1'b1, 3, srst));
    op_valid = 1'b1;
    op_type = 3'd0;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    for (int k = gcyc; k < gcyc + 14; k++) exp_q[k] = idle_o();
    chk("pre_rst_block", 32'(trans_block), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({op_ready, trans_block, tlbserch_en, tlb_wen, tlb_fill_en,
        tlbinv_en, tlbrd_en, srch_wr, op_done, op_excp, refetch_req}), 32'h400);
    chk("rst_async_inv_op", 32'(tlbinv_op), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;

    // FILL accepted on the 40th edge after reset release takes index 40 mod 32.
    for (int i = 0; i < 100 && srst != 39; i++) begin
      @(posedge clk);
      #1;
    end
    chk("fill_align", 32'(srst), 32'd39);
    run_op(3, 0, 0, 0, 0, -1, 1, 1'b0, 0, a);
    r1 = int'(samp[a+2].rnd);
    chk("fill40_pulse", 32'(samp[a+2].fill), 32'd1);
    chk("fill40_index", 32'(r1), 32'd8);
    run_op(3, 0, 0, 0, 0, -1, 1, 1'b0, 0, a);
    r2 = int'(samp[a+2].rnd);
    chk("fill_b2b_index", 32'(r2), 32'd13);
    chk("fill_b2b_differ", 32'(r1 != r2), 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
